wb_front: RTL and testbench

- Wishbone slave front end that sits directly upstream of the config/routing macro.
- Accepts classic Wishbone cycles from the Caravel bus and registers each one.
- Issues a single-cycle command strobe (wb_cmd_*) to the config macro and waits for its read ack (wb_rd_ack/wb_rd_dat).
- Returns wbs_ack_o/wbs_dat_o to the master. A read timeout guarantees the bus never hangs.

---
 rtl/wb_front.sv | 117 +++++++++++
 tb/tb_wb_front.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_front.sv
// Wishbone slave front end for the config/routing macro: registers each bus
// cycle, issues a one-cycle command strobe and returns the ack or a timeout.
module wb_front #(
  parameter int unsigned TIMEOUT     = 64,
  parameter logic [31:0] TIMEOUT_DAT = 32'hDEAD_DEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        wb_cmd_val,
  output logic [31:0] wb_cmd_adr,
  output logic        wb_cmd_we,
  output logic [3:0]  wb_cmd_sel,
  output logic [31:0] wb_cmd_dat,
  input  logic        wb_rd_ack,
  input  logic [31:0] wb_rd_dat,
  output logic        busy,
  output logic [7:0]  to_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_ACK} state_e;

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } cmd_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdat_q, rdat_d;
  logic [7:0]  to_cnt_q, to_cnt_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cmd_d    = cmd_q;
    cnt_d    = cnt_q;
    rdat_d   = rdat_q;
    to_cnt_d = to_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          cmd_d   = '{adr: wbs_adr_i, we: wbs_we_i, sel: wbs_sel_i, dat: wbs_dat_i};
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        cnt_d = '0;
        if (cmd_q.we) begin
          state_d = S_ACK;
        end else if (wb_rd_ack) begin
          rdat_d  = wb_rd_dat;
          state_d = S_ACK;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // An abandoned cycle wins over everything: the master no longer wants an ack.
        if (!wbs_cyc_i) begin
          state_d = S_IDLE;
        end else if (wb_rd_ack) begin
          rdat_d  = wb_rd_dat;
          state_d = S_ACK;
        end else if (cnt_q == TO_LAST) begin
          rdat_d  = TIMEOUT_DAT;
          if (to_cnt_q != 8'hFF) to_cnt_d = to_cnt_q + 8'd1;
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      cnt_q    <= '0;
      rdat_q   <= '0;
      to_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates together at the edge.
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      rdat_q   <= rdat_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Strobes are pure state decodes, so reset removes them asynchronously.
  assign wb_cmd_val = (state_q == S_CMD);
  assign wbs_ack_o  = (state_q == S_ACK);
  assign busy       = (state_q != S_IDLE);
  assign wb_cmd_adr = cmd_q.adr;
  assign wb_cmd_we  = cmd_q.we;
  assign wb_cmd_sel = cmd_q.sel;
  assign wb_cmd_dat = cmd_q.dat;
  assign wbs_dat_o  = rdat_q;
  assign to_cnt     = to_cnt_q;

endmodule

// File: tb/tb_wb_front.sv
// Directed bench for wb_front: writes, reads, timeouts, aborts and reset.
module tb_wb_front;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        ack;
  logic [31:0] dat_o;
  logic        cmd_val;
  logic [31:0] cmd_adr;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_dat;
  logic        rd_ack;
  logic [31:0] rd_dat;
  logic        busy;
  logic [7:0]  to_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_front dut (
    .clk        (clk),
    .rst        (rst),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dat_o),
    .wb_cmd_val (cmd_val),
    .wb_cmd_adr (cmd_adr),
    .wb_cmd_we  (cmd_we),
    .wb_cmd_sel (cmd_sel),
    .wb_cmd_dat (cmd_dat),
    .wb_rd_ack  (rd_ack),
    .wb_rd_dat  (rd_dat),
    .busy       (busy),
    .to_cnt     (to_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_dat_o"}, dat_o, 32'd0);
    check({tag, "_cmd_val"}, 32'(cmd_val), 32'd0);
    check({tag, "_cmd_adr"}, cmd_adr, 32'd0);
    check({tag, "_cmd_we"}, 32'(cmd_we), 32'd0);
    check({tag, "_cmd_sel"}, 32'(cmd_sel), 32'd0);
    check({tag, "_cmd_dat"}, cmd_dat, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_to_cnt"}, 32'(to_cnt), 32'd0);
  endtask

  // Starts in an IDLE cycle (cycle 0); returns the cycle the ack appeared in, or -1.
  task automatic run_read(input logic [31:0] a, input int ack_cyc, input logic [31:0] rdat,
                          output int ack_at);
    int n = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF; dat = '0;
    ack_at = -1;
    while (n < 200 && ack_at < 0) begin
      if (n == ack_cyc) begin
        rd_ack = 1'b1;
        rd_dat = rdat;
      end
      next_cycle();
      n++;
      rd_ack = 1'b0;
      if (ack) ack_at = n;
    end
    cyc = 1'b0; stb = 1'b0;
    next_cycle();
  endtask

  task automatic run_write(input logic [31:0] a, input logic [31:0] d, output int ack_at);
    int n = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; sel = 4'hF; dat = d;
    ack_at = -1;
    while (n < 20 && ack_at < 0) begin
      next_cycle();
      n++;
      if (ack) ack_at = n;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    next_cycle();
  endtask

  initial begin
    int ack_at;
    logic seen;
    rst = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat = '0;
    rd_ack = 1'b0; rd_dat = '0;
    #1;
    check_all_zero("reset");
    #21 rst = 1'b1;
    next_cycle();

    // Posted write: command in cycle 1, ack in cycle 2.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0004; dat = 32'h1234_5678; sel = 4'hF;
    next_cycle();
    check("wr_cmd_val_c1", 32'(cmd_val), 32'd1);
    check("wr_cmd_adr", cmd_adr, 32'h3000_0004);
    check("wr_cmd_dat", cmd_dat, 32'h1234_5678);
    check("wr_cmd_sel", 32'(cmd_sel), 32'hF);
    check("wr_cmd_we", 32'(cmd_we), 32'd1);
    check("wr_ack_c1", 32'(ack), 32'd0);
    next_cycle();
    check("wr_ack_c2", 32'(ack), 32'd1);
    check("wr_cmd_val_c2", 32'(cmd_val), 32'd0);
    check("wr_dat_o", dat_o, 32'd0);
    check("wr_cmd_adr_stable", cmd_adr, 32'h3000_0004);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    next_cycle();
    check("wr_ack_c3", 32'(ack), 32'd0);
    check("wr_busy_c3", 32'(busy), 32'd0);

    // Read completed by the macro in cycle 3.
    run_read(32'h3000_0010, 3, 32'hCAFE_F00D, ack_at);
    check("rd_ack_at", 32'(ack_at), 32'd4);
    check("rd_dat_o", dat_o, 32'hCAFE_F00D);
    check("rd_to_cnt", 32'(to_cnt), 32'd0);

    // Read completed while still in CMD.
    run_read(32'h3000_0014, 1, 32'h0102_0304, ack_at);
    check("rd_cmd_ack_at", 32'(ack_at), 32'd2);
    check("rd_cmd_dat_o", dat_o, 32'h0102_0304);

    // Timed-out read.
    run_read(32'h3000_0018, -1, 32'h0, ack_at);
    check("to_ack_at", 32'(ack_at), 32'd66);
    check("to_dat_o", dat_o, 32'hDEAD_DEAD);
    check("to_cnt_1", 32'(to_cnt), 32'd1);

    // Macro ack one cycle before the timeout would fire.
    run_read(32'h3000_001C, 64, 32'h7777_0064, ack_at);
    check("late_ack_at", 32'(ack_at), 32'd65);
    check("late_dat_o", dat_o, 32'h7777_0064);
    check("late_to_cnt", 32'(to_cnt), 32'd1);

    // Macro ack in the very cycle the timeout would fire: ack wins.
    run_read(32'h3000_0020, 65, 32'h5A5A_1234, ack_at);
    check("tie_ack_at", 32'(ack_at), 32'd66);
    check("tie_dat_o", dat_o, 32'h5A5A_1234);
    check("tie_to_cnt", 32'(to_cnt), 32'd1);

    // Read abandoned in WAIT, late macro ack must be ignored.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0024; sel = 4'hF;
    next_cycle();
    next_cycle();
    next_cycle();
    cyc = 1'b0; stb = 1'b0;
    seen = 1'b0;
    for (int n = 3; n < 9; n++) begin
      if (n == 5) begin
        rd_ack = 1'b1;
        rd_dat = 32'h1111_2222;
      end
      next_cycle();
      rd_ack = 1'b0;
      if (ack) seen = 1'b1;
      if (n == 3) check("abort_busy_c4", 32'(busy), 32'd0);
    end
    check("abort_no_ack", 32'(seen), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dat_o", dat_o, 32'h5A5A_1234);
    run_write(32'h3000_0028, 32'hA5A5_A5A5, ack_at);
    check("abort_wr_ack_at", 32'(ack_at), 32'd2);
    check("abort_wr_dat_o", dat_o, 32'h5A5A_1234);
    check("abort_wr_cmd_dat", cmd_dat, 32'hA5A5_A5A5);

    // Saturation: 300 timed-out reads in total.
    for (int i = 0; i < 299; i++) begin
      run_read(32'h3000_0030, -1, 32'h0, ack_at);
      if (i == 252) check("sat_to_cnt_254", 32'(to_cnt), 32'd254);
      if (i == 253) check("sat_to_cnt_255", 32'(to_cnt), 32'd255);
    end
    check("sat_to_cnt_final", 32'(to_cnt), 32'd255);
    check("sat_last_ack_at", 32'(ack_at), 32'd66);

    // Back-to-back write then read with stb held high, then reset during a third read.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0040; dat = 32'h0000_BEEF; sel = 4'h3;
    next_cycle();
    check("b2b_wr_cmd_c1", 32'(cmd_val), 32'd1);
    next_cycle();
    check("b2b_wr_ack_c2", 32'(ack), 32'd1);
    next_cycle();
    we = 1'b0; adr = 32'h3000_0044; sel = 4'hF;
    check("b2b_ack_c3", 32'(ack), 32'd0);
    next_cycle();
    check("b2b_rd_cmd_c4", 32'(cmd_val), 32'd1);
    check("b2b_rd_cmd_we", 32'(cmd_we), 32'd0);
    check("b2b_rd_cmd_adr", cmd_adr, 32'h3000_0044);
    rd_ack = 1'b1; rd_dat = 32'h0BAD_BEEF;
    next_cycle();
    rd_ack = 1'b0;
    check("b2b_rd_ack_c5", 32'(ack), 32'd1);
    check("b2b_rd_dat_o", dat_o, 32'h0BAD_BEEF);
    adr = 32'h3000_0048;
    next_cycle();
    next_cycle();
    check("b2b_3rd_cmd", 32'(cmd_val), 32'd1);
    next_cycle();
    next_cycle();
    check("b2b_3rd_wait", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_all_zero("midrst");
    next_cycle();
    check("midrst_no_ack", 32'(ack), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    #2 rst = 1'b1;
    next_cycle();
    check("postrst_ack", 32'(ack), 32'd0);
    check("postrst_busy", 32'(busy), 32'd0);
    run_write(32'h3000_004C, 32'h4242_4242, ack_at);
    check("postrst_wr_ack_at", 32'(ack_at), 32'd2);
    check("postrst_to_cnt", 32'(to_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
